// File: rtl/onewire_temp_seq.sv
`default_nettype none
// ============================================================================
// Module   : onewire_temp_seq
// Purpose  : Temperature-read sequencer driving the 1-Wire byte master.
//            Reset/SKIP ROM/CONVERT T, conversion wait, reset/SKIP ROM/
//            READ SCRATCHPAD, then scratchpad byte reads into temp.
// Options  : ONEWIRE_CRC_EN - read all 9 scratchpad bytes and check the
//            Dallas CRC-8 carried in byte 8.
// Revision : 1.0 - initial release
// ============================================================================
module onewire_temp_seq #(
  parameter int CONV_WAIT   = 75,
  parameter int POLL_PERIOD = 100
) (
  input  logic        clk_10,
  input  logic        arst_n,
  input  logic        tick_10ms,
  input  logic        start,
  input  logic        ow_rdy,
  output logic        ow_vld,
  output logic [1:0]  ow_op,
  output logic [7:0]  ow_wdat,
  input  logic        ow_done,
  input  logic [7:0]  ow_rdat,
  input  logic        ow_presence,
  output logic [15:0] temp,
  output logic        temp_vld,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RST1   = 4'd1,
    ST_SKIP1  = 4'd2,
    ST_CONV   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_RST2   = 4'd5,
    ST_SKIP2  = 4'd6,
    ST_RDCMD  = 4'd7,
    ST_RDBYTE = 4'd8,
    ST_DONE   = 4'd9
  } state_t;

  localparam logic [7:0]  c_conv_wait   = 8'(CONV_WAIT);
  localparam logic [15:0] c_poll_period = 16'(POLL_PERIOD);
`ifdef ONEWIRE_CRC_EN
  localparam logic [3:0]  c_last_idx    = 4'd8;
`else
  localparam logic [3:0]  c_last_idx    = 4'd1;
`endif

  state_t      r_state,    w_state_nxt;
  logic        r_issued,   w_issued_nxt;
  logic [3:0]  r_idx,      w_idx_nxt;
  logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        r_wait_arm, w_wait_arm_nxt;
  logic [15:0] r_poll_cnt, w_poll_cnt_nxt;
  logic [15:0] r_shadow,   w_shadow_nxt;
  logic        r_err,      w_err_nxt;
  logic        r_busy,     w_busy_nxt;
  logic [15:0] r_temp,     w_temp_nxt;
  logic        r_temp_vld, w_temp_vld_nxt;
  logic        r_vld,      w_vld_nxt;
  logic [1:0]  r_op,       w_op_nxt;
  logic [7:0]  r_wdat,     w_wdat_nxt;
  logic        w_cmd;
  logic [1:0]  w_cmd_op;
  logic [7:0]  w_cmd_wdat;
  logic        w_poll_hit;
`ifdef ONEWIRE_CRC_EN
  logic [7:0]  r_crc,      w_crc_nxt;

  // One byte of Dallas CRC-8 (x^8+x^5+x^4+1), data shifted in LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    logic       mix;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      mix = c[0] ^ data[i];
      c   = {1'b0, c[7:1]};
      if (mix) c = c ^ 8'h8C;
    end
    return c;
  endfunction
`endif

  assign ow_vld   = r_vld;
  assign ow_op    = r_op;
  assign ow_wdat  = r_wdat;
  assign temp     = r_temp;
  assign temp_vld = r_temp_vld;
  assign busy     = r_busy;
  assign err      = r_err;

  // Auto-poll fires on the tick that brings the idle count up to the period.
  assign w_poll_hit = (c_poll_period != 16'd0) && tick_10ms &&
                      (r_poll_cnt >= (c_poll_period - 16'd1));

  // State register and registered outputs; async reset aborts any transaction.
  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_issued   <= 1'b0;
      r_idx      <= 4'd0;
      r_wait_cnt <= 8'd0;
      r_wait_arm <= 1'b0;
      r_poll_cnt <= 16'd0;
      r_shadow   <= 16'h0000;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_temp     <= 16'h0000;
      r_temp_vld <= 1'b0;
      r_vld      <= 1'b0;
      r_op       <= 2'b00;
      r_wdat     <= 8'h00;
`ifdef ONEWIRE_CRC_EN
      r_crc      <= 8'h00;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_issued   <= w_issued_nxt;
      r_idx      <= w_idx_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_wait_arm <= w_wait_arm_nxt;
      r_poll_cnt <= w_poll_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_temp     <= w_temp_nxt;
      r_temp_vld <= w_temp_vld_nxt;
      r_vld      <= w_vld_nxt;
      r_op       <= w_op_nxt;
      r_wdat     <= w_wdat_nxt;
`ifdef ONEWIRE_CRC_EN
      r_crc      <= w_crc_nxt;
`endif
    end
  end

  // Next-state: command issue/wait-done handshake plus idle, wait and done housekeeping.
  always_comb begin
    w_state_nxt    = r_state;
    w_issued_nxt   = r_issued;
    w_idx_nxt      = r_idx;
    w_wait_cnt_nxt = r_wait_cnt;
    w_wait_arm_nxt = r_wait_arm;
    w_poll_cnt_nxt = r_poll_cnt;
    w_shadow_nxt   = r_shadow;
    w_err_nxt      = r_err;
    w_busy_nxt     = r_busy;
    w_temp_nxt     = r_temp;
    w_temp_vld_nxt = 1'b0;
    w_vld_nxt      = 1'b0;
    w_op_nxt       = r_op;
    w_wdat_nxt     = r_wdat;
`ifdef ONEWIRE_CRC_EN
    w_crc_nxt      = r_crc;
`endif
    w_cmd          = 1'b0;
    w_cmd_op       = 2'b00;
    w_cmd_wdat     = 8'h00;

    case (r_state)
      ST_RST1, ST_RST2:   begin w_cmd = 1'b1; w_cmd_op = 2'b10; end
      ST_SKIP1, ST_SKIP2: begin w_cmd = 1'b1; w_cmd_wdat = 8'hCC; end
      ST_CONV:            begin w_cmd = 1'b1; w_cmd_wdat = 8'h44; end
      ST_RDCMD:           begin w_cmd = 1'b1; w_cmd_wdat = 8'hBE; end
      ST_RDBYTE:          begin w_cmd = 1'b1; w_cmd_op = 2'b01; end
      default:            ;
    endcase

    if (w_cmd) begin
      if (!r_issued) begin
        // Single strobe on the first cycle the master is ready.
        if (ow_rdy) begin
          w_vld_nxt    = 1'b1;
          w_op_nxt     = w_cmd_op;
          w_wdat_nxt   = w_cmd_wdat;
          w_issued_nxt = 1'b1;
        end
      end else if (ow_done) begin
        w_issued_nxt = 1'b0;
        case (r_state)
          ST_RST1: begin
            if (ow_presence) w_state_nxt = ST_SKIP1;
            else begin w_err_nxt = 1'b1; w_state_nxt = ST_DONE; end
          end
          ST_SKIP1: w_state_nxt = ST_CONV;
          ST_CONV: begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = 8'd0;
            w_wait_arm_nxt = 1'b0;
          end
          ST_RST2: begin
            if (ow_presence) w_state_nxt = ST_SKIP2;
            else begin w_err_nxt = 1'b1; w_state_nxt = ST_DONE; end
          end
          ST_SKIP2: w_state_nxt = ST_RDCMD;
          ST_RDCMD: begin
            w_state_nxt = ST_RDBYTE;
            w_idx_nxt   = 4'd0;
          end
          ST_RDBYTE: begin
            if (r_idx == 4'd0) w_shadow_nxt[7:0]  = ow_rdat;
            if (r_idx == 4'd1) w_shadow_nxt[15:8] = ow_rdat;
`ifdef ONEWIRE_CRC_EN
            if (r_idx != c_last_idx) w_crc_nxt = crc8_byte(r_crc, ow_rdat);
`endif
            if (r_idx == c_last_idx) begin
              w_state_nxt = ST_DONE;
`ifdef ONEWIRE_CRC_EN
              if (ow_rdat != r_crc) w_err_nxt = 1'b1;
`endif
            end else begin
              w_idx_nxt = r_idx + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (start || w_poll_hit) begin
          w_state_nxt    = ST_RST1;
          w_busy_nxt     = 1'b1;
          w_err_nxt      = 1'b0;
          w_poll_cnt_nxt = 16'd0;
          w_issued_nxt   = 1'b0;
          w_idx_nxt      = 4'd0;
`ifdef ONEWIRE_CRC_EN
          w_crc_nxt      = 8'h00;
`endif
        end else if (tick_10ms && (r_poll_cnt < c_poll_period)) begin
          w_poll_cnt_nxt = r_poll_cnt + 16'd1;
        end
      end
      ST_WAIT: begin
        // The first cycle in WAIT only arms the counter, so a tick there is not counted.
        if (!r_wait_arm) begin
          w_wait_arm_nxt = 1'b1;
        end else if (tick_10ms) begin
          if ((r_wait_cnt + 8'd1) == c_conv_wait) w_state_nxt = ST_RST2;
          else w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        if (!r_err) begin
          w_temp_nxt     = r_shadow;
          w_temp_vld_nxt = 1'b1;
        end
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_onewire_temp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_onewire_temp_seq
// Purpose  : Self-checking bench for onewire_temp_seq with a behavioural
//            1-Wire master model; honours ONEWIRE_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onewire_temp_seq;

  localparam int CW = 3;
  localparam int PP = 2;
`ifdef ONEWIRE_CRC_EN
  localparam int NRD = 9;
`else
  localparam int NRD = 2;
`endif
  localparam int NCMD = 6 + NRD;
  localparam int NV = 5;

  logic        clk_10 = 1'b0;
  logic        arst_n = 1'b0;
  logic        tick_10ms = 1'b0;
  logic        start = 1'b0;
  logic        ow_rdy = 1'b1;
  logic        ow_vld;
  logic [1:0]  ow_op;
  logic [7:0]  ow_wdat;
  logic        ow_done = 1'b0;
  logic [7:0]  ow_rdat = 8'h00;
  logic        ow_presence = 1'b0;
  logic [15:0] temp;
  logic        temp_vld;
  logic        busy;
  logic        err;

  onewire_temp_seq #(.CONV_WAIT(CW), .POLL_PERIOD(PP)) dut (
    .clk_10(clk_10), .arst_n(arst_n), .tick_10ms(tick_10ms), .start(start),
    .ow_rdy(ow_rdy), .ow_vld(ow_vld), .ow_op(ow_op), .ow_wdat(ow_wdat),
    .ow_done(ow_done), .ow_rdat(ow_rdat), .ow_presence(ow_presence),
    .temp(temp), .temp_vld(temp_vld), .busy(busy), .err(err)
  );

  always #50 clk_10 = ~clk_10;

  int n_cmp = 0;
  int n_bad = 0;

  // Master model state
  logic [1:0]  log_op   [64];
  logic [7:0]  log_wdat [64];
  int          vld_cyc  [64];
  int          log_n = 0, cyc = 0, m_cnt = 0, cur_idx = 0, hold_idx = -1, hold_left = 0;
  int          rst_idx = 0, rd_idx = 0, win_ph = 0, win_ticks = 0, tick_req = 0;
  int          tv_cnt = 0, viol = 0, rdy_rise_cyc = 0;
  logic [1:0]  cur_op = 2'b00;
  bit          m_busy = 1'b0, win = 1'b0, pres1 = 1'b1, pres2 = 1'b1;
  logic [71:0] rd_sp = 72'h0;

  typedef struct {
    bit          p1;
    bit          p2;
    logic [71:0] sp;
    logic [15:0] e_temp;
    bit          e_err;
    int          e_ncmd;
    int          e_tv;
  } vec_t;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural 1-Wire master: accepts a strobe, completes 4 cycles later,
  // and produces tick_10ms (periodic during conversion wait, or on request).
  initial begin
    forever begin
      @(negedge clk_10);
      cyc++;
      ow_done   = 1'b0;
      tick_10ms = 1'b0;
      if (temp_vld) tv_cnt++;
      if (!arst_n) begin
        m_busy = 1'b0; win = 1'b0; hold_left = 0; ow_rdy = 1'b1;
      end else begin
        if (ow_vld) begin
          if (!ow_rdy || m_busy) viol++;
          if (log_n < 64) begin
            log_op[log_n] = ow_op; log_wdat[log_n] = ow_wdat; vld_cyc[log_n] = cyc;
          end
          cur_idx = log_n; cur_op = ow_op; log_n++;
          if (cur_idx == 3) win = 1'b0;
          m_busy = 1'b1; m_cnt = 4; ow_rdy = 1'b0;
        end else if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy  = 1'b0;
            ow_done = 1'b1;
            if (cur_op == 2'b10) begin
              ow_presence = (rst_idx == 0) ? pres1 : pres2;
              rst_idx++; rd_idx = 0;
            end else if (cur_op == 2'b01) begin
              ow_rdat = (rd_idx < 9) ? rd_sp[8*rd_idx +: 8] : 8'h00;
              rd_idx++;
            end
            if (cur_idx == 2) begin win = 1'b1; win_ph = 0; win_ticks = 0; end
            if (cur_idx == hold_idx) hold_left = 20;
            else ow_rdy = 1'b1;
          end
        end else if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) begin ow_rdy = 1'b1; rdy_rise_cyc = cyc; end
        end
        if (win) begin
          win_ph++;
          if (win_ph % 7 == 3) begin tick_10ms = 1'b1; win_ticks++; end
        end else if (tick_req > 0) begin
          tick_10ms = 1'b1; tick_req--;
        end
      end
    end
  end

  initial begin
    #(60000 * 100);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_log();
    log_n = 0; rst_idx = 0; rd_idx = 0; tv_cnt = 0; win_ticks = 0; viol = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_10); start = 1'b1;
    @(negedge clk_10); start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin @(negedge clk_10); t++; end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", t);
    end
    repeat (3) @(negedge clk_10);
  endtask

  function automatic logic [1:0] exp_op(input int i);
    if (i == 0 || i == 3) return 2'b10;
    if (i >= 6) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_wdat(input int i);
    if (i == 2) return 8'h44;
    if (i == 5) return 8'hBE;
    return 8'hCC;
  endfunction

  initial begin
    int lat;
    int t;
`ifdef ONEWIRE_CRC_EN
    vt[0] = '{1'b0, 1'b1, 72'h0,                     16'h0000, 1'b1, 1,    0};
    vt[1] = '{1'b1, 1'b1, 72'h25100FFF7F464B0191,    16'h0191, 1'b0, NCMD, 1};
    vt[2] = '{1'b1, 1'b1, 72'h24100FFF7F464B0191,    16'h0191, 1'b1, NCMD, 0};
    vt[3] = '{1'b1, 1'b0, 72'h0,                     16'h0191, 1'b1, 4,    0};
    vt[4] = '{1'b1, 1'b1, 72'h0,                     16'h0000, 1'b0, NCMD, 1};
`else
    vt[0] = '{1'b0, 1'b1, 72'h0,    16'h0000, 1'b1, 1,    0};
    vt[1] = '{1'b1, 1'b1, 72'h0191, 16'h0191, 1'b0, NCMD, 1};
    vt[2] = '{1'b1, 1'b1, 72'h0550, 16'h0550, 1'b0, NCMD, 1};
    vt[3] = '{1'b1, 1'b0, 72'hAA55, 16'h0550, 1'b1, 4,    0};
    vt[4] = '{1'b1, 1'b1, 72'h0000, 16'h0000, 1'b0, NCMD, 1};
`endif

    // Reset values
    repeat (3) @(negedge clk_10);
    chk("rst_ow_vld", {31'd0, ow_vld}, 32'd0);
    chk("rst_ow_op", {30'd0, ow_op}, 32'd0);
    chk("rst_ow_wdat", {24'd0, ow_wdat}, 32'd0);
    chk("rst_temp", {16'd0, temp}, 32'd0);
    chk("rst_temp_vld", {31'd0, temp_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    arst_n = 1'b1;
    repeat (3) @(negedge clk_10);

    // Table-driven measurements
    for (int v = 0; v < NV; v++) begin
      pres1 = vt[v].p1; pres2 = vt[v].p2; rd_sp = vt[v].sp;
      clr_log();
      pulse_start();
      wait_idle();
      chk($sformatf("v%0d_temp", v), {16'd0, temp}, {16'd0, vt[v].e_temp});
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vt[v].e_err});
      chk($sformatf("v%0d_ncmd", v), log_n, vt[v].e_ncmd);
      chk($sformatf("v%0d_temp_vld_cnt", v), tv_cnt, vt[v].e_tv);
      chk($sformatf("v%0d_handshake_viol", v), viol, 0);
      for (int i = 0; i < log_n && i < vt[v].e_ncmd && i < 64; i++) begin
        chk($sformatf("v%0d_op%0d", v, i), {30'd0, log_op[i]}, {30'd0, exp_op(i)});
        if (exp_op(i) == 2'b00)
          chk($sformatf("v%0d_wdat%0d", v, i), {24'd0, log_wdat[i]}, {24'd0, exp_wdat(i)});
      end
      if (vt[v].e_ncmd >= 4)
        chk($sformatf("v%0d_wait_ticks", v), win_ticks, CW);
    end

    pres1 = 1'b1; pres2 = 1'b1; rd_sp = vt[1].sp;

    // Latency from start to first command strobe
    clr_log();
    @(negedge clk_10); start = 1'b1;
    @(negedge clk_10); start = 1'b0;
    lat = 1;
    while (!ow_vld && lat < 10) begin @(negedge clk_10); lat++; end
    chk("start_to_vld_latency", lat, 2);
    wait_idle();
    chk("lat_run_temp", {16'd0, temp}, 32'h0191);

    // ow_rdy held low for 20 cycles in SKIP1
    clr_log();
    hold_idx = 0;
    pulse_start();
    wait_idle();
    hold_idx = -1;
    chk("hold_ncmd", log_n, NCMD);
    chk("hold_viol", viol, 0);
    chk("hold_vld_after_rdy", vld_cyc[1] - rdy_rise_cyc, 1);
    chk("hold_op1", {24'd0, log_wdat[1]}, 32'h00CC);

    // start pulsed repeatedly while busy
    clr_log();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      repeat (10) @(negedge clk_10);
      start = 1'b1;
      @(negedge clk_10);
      start = 1'b0;
    end
    chk("multi_start_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    repeat (20) @(negedge clk_10);
    chk("multi_start_ncmd", log_n, NCMD);
    chk("multi_start_tv", tv_cnt, 1);
    chk("multi_start_idle", {31'd0, busy}, 32'd0);

    // Auto-poll after the second idle tick
    clr_log();
    tick_req = 1;
    repeat (6) @(negedge clk_10);
    chk("poll_one_tick_busy", {31'd0, busy}, 32'd0);
    chk("poll_one_tick_ncmd", log_n, 0);
    tick_req = 1;
    t = 0;
    while (!busy && t < 6) begin @(negedge clk_10); t++; end
    chk("poll_autostart", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("poll_ncmd", log_n, NCMD);
    chk("poll_tv", tv_cnt, 1);

    // start and poll trigger together: one measurement
    clr_log();
    tick_req = 1;
    repeat (6) @(negedge clk_10);
    tick_req = 1;
    start = 1'b1;
    @(negedge clk_10);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk_10);
    chk("both_trig_ncmd", log_n, NCMD);
    chk("both_trig_tv", tv_cnt, 1);

    // Asynchronous reset during the conversion wait
    clr_log();
    pulse_start();
    t = 0;
    while (!win && t < 300) begin @(negedge clk_10); t++; end
    chk("reached_wait", {31'd0, win}, 32'd1);
    repeat (5) @(negedge clk_10);
    arst_n = 1'b0;
    #1;
    chk("arst_ow_vld", {31'd0, ow_vld}, 32'd0);
    chk("arst_ow_op", {30'd0, ow_op}, 32'd0);
    chk("arst_ow_wdat", {24'd0, ow_wdat}, 32'd0);
    chk("arst_temp", {16'd0, temp}, 32'd0);
    chk("arst_temp_vld", {31'd0, temp_vld}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk_10);
    arst_n = 1'b1;
    clr_log();
    repeat (30) @(negedge clk_10);
    chk("arst_no_vld", log_n, 0);
    chk("arst_idle", {31'd0, busy}, 32'd0);
    pulse_start();
    wait_idle();
    chk("arst_rerun_ncmd", log_n, NCMD);
    chk("arst_rerun_first_op", {30'd0, log_op[0]}, 32'd2);
    chk("arst_rerun_temp", {16'd0, temp}, 32'h0191);
    chk("arst_rerun_tv", tv_cnt, 1);
    chk("arst_rerun_ticks", win_ticks, CW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onewire_temp_seq.md
Name: onewire_temp_seq

Overview:
- Transaction sequencer for the 1-Wire byte master. Runs a DS18B20-style temperature read on a single-drop bus:
  - reset/presence, SKIP ROM 0xCC, CONVERT T 0x44, conversion wait;
  - reset/presence, SKIP ROM 0xCC, READ SCRATCHPAD 0xBE, read scratchpad bytes.
- Sits between the tick generators and the onewire master. Publishes the 16-bit temperature word to the UART/LED logic.
- Owns the master's command port exclusively.

Parameters:
- CONV_WAIT, 75, conversion wait in tick_10ms periods (75 = 750 ms). Legal range 1..255.
- POLL_PERIOD, 100, tick_10ms periods between automatic measurements. 0 disables auto-polling.

Ports:
- clk_10  in  1  system clock, 10 MHz.
- arst_n  in  1  asynchronous active-low reset.
- tick_10ms  in  1  single-cycle strobe every 10 ms.
- start  in  1  single-cycle request for one measurement. Ignored when busy=1.
- ow_rdy  in  1  master idle, able to accept a command.
- ow_vld  out  1  single-cycle command strobe. Asserted only while ow_rdy=1.
- ow_op  out  2  command: 00 write byte, 01 read byte, 10 reset/presence, 11 reserved (never issued).
- ow_wdat  out  8  write byte. Valid with ow_vld when ow_op=00.
- ow_done  in  1  single-cycle completion strobe for the last command.
- ow_rdat  in  8  read byte. Valid with ow_done after op 01.
- ow_presence  in  1  presence detected. Valid with ow_done after op 10.
- temp  out  16  last good scratchpad bytes {byte1, byte0}.
- temp_vld  out  1  single-cycle strobe when temp updates.
- busy  out  1  measurement in progress.
- err  out  1  sticky flag: no presence (or CRC fail), cleared by the next start.

Behaviour:
- Reset values: ow_vld=0, ow_op=00, ow_wdat=0x00, temp=0x0000, temp_vld=0, busy=0, err=0. State=IDLE, poll counter=0.
- Reset mid-operation: all state returns to IDLE immediately. No further ow_vld is issued. Completion strobes from the master arriving after reset are ignored.
- FSM states: IDLE, RST1, SKIP1, CONV, WAIT, RST2, SKIP2, RDCMD, RDBYTE, DONE.
  - Each command state has an ISSUE phase and a WAIT_DONE phase.
  - ISSUE: hold op/wdat; assert ow_vld for exactly 1 cycle at the first cycle with ow_rdy=1.
  - WAIT_DONE: wait for ow_done. Then advance on the next edge. ow_done seen outside WAIT_DONE is ignored.
- IDLE leaves on either trigger:
  - start=1, or
  - the poll counter reaching POLL_PERIOD on a tick_10ms.
  - If both occur in the same cycle, only one measurement runs.
  - On leaving IDLE: busy=1, err=0, poll counter cleared.
- RST1 / RST2: op=10.
  - ow_presence=0 at done: err=1 and go to DONE without updating temp.
- SKIP1 / SKIP2: op=00, wdat=0xCC.
- CONV: op=00, wdat=0x44.
- WAIT: counts tick_10ms strobes. Leaves after exactly CONV_WAIT strobes. A strobe in the entry cycle is not counted.
- RDCMD: op=00, wdat=0xBE.
- RDBYTE: op=01, repeated N times with a byte index 0..N-1.
  - N=2 without the optional feature.
  - byte0 goes to a temp LSB shadow, byte1 to a temp MSB shadow.
- DONE, for 1 cycle:
  - If err=0: temp <= shadow and temp_vld=1.
  - busy=0 next cycle; return to IDLE.
- start while busy: dropped, not queued.
- The poll counter increments only in IDLE on tick_10ms and saturates at POLL_PERIOD.
- Latency from start to the first ow_vld: 2 cycles when ow_rdy=1.

Optional Feature:
- Macro ONEWIRE_CRC_EN.
- Defined:
  - N=9; all scratchpad bytes are read.
  - Dallas CRC-8 (poly x^8+x^5+x^4+1, LSB-first, init 0x00) runs over bytes 0..7.
  - Byte 8 must equal the CRC. On mismatch: err=1, temp unchanged, no temp_vld.
  - All-0x00 scratchpad (CRC 0x00) counts as a pass.
- Undefined: N=2, no CRC logic, err set only on no presence.

Test Plan:
- Model presence=1; reads return 0x91 then 0x01; pulse start:
  - ow_vld sequence (op/wdat): 10, 00/CC, 00/44, 10, 00/CC, 00/BE, 01, 01;
  - CONV_WAIT=3 yields exactly 3 tick_10ms between the 0x44 done and the second reset;
  - temp=0x0191, one temp_vld pulse, then busy=0.
- Presence=0 on the first reset: err=1, no further ow_vld, temp stays 0x0000, no temp_vld. A following start clears err.
- ow_rdy held low for 20 cycles during SKIP1: ow_vld stays 0, then pulses exactly once, 1 cycle after ow_rdy rises.
- start pulsed 5 times during a busy measurement: exactly one measurement runs. POLL_PERIOD=2: auto-start after the 2nd idle tick_10ms.
- arst_n low during WAIT: all outputs return to reset values within the same cycle. The next start runs a complete sequence beginning with op 10.
- ONEWIRE_CRC_EN defined; scratchpad 91 01 4B 46 7F FF 0F 10 25:
  - valid CRC: temp=0x0191;
  - byte 8 flipped to 0x24: err=1, no temp_vld.
